// File: rtl/procesador_multiciclo.sv
// Multicycle MIPS-subset core: one FSM sequences a register bank, ALU, PC and IR against req/ack memories.
// Define MC_JUMP_EN to make opcode 000010 (j) legal; otherwise it is trapped as illegal and executed as a NOP.
module procesador_multiciclo #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic [ADDR_W-1:0] pc_o,
    output logic [2:0]        state_o,
    output logic              illegal_o
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [31:0]         r_ir;
    logic [XLEN-1:0]     r_a, r_b, r_imm, r_alu, r_mdr;
    logic                r_illegal;

    logic [5:0]          w_op, w_funct;
    logic [4:0]          w_rs, w_rt, w_rd;
    logic                w_is_r, w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_r_ok, w_legal;
    logic [XLEN-1:0]     w_alu;
    logic [XLEN-1:0]     w_rf [32];
    logic                w_rf_we;
    logic [4:0]          w_rf_waddr;
    logic [XLEN-1:0]     w_rf_wdata;
    logic                w_unused;

    assign w_op      = r_ir[31:26];
    assign w_rs      = r_ir[25:21];
    assign w_rt      = r_ir[20:16];
    assign w_rd      = r_ir[15:11];
    assign w_funct   = r_ir[5:0];
    assign w_unused  = ^r_ir[10:6];
    assign w_is_r    = (w_op == OP_R);
    assign w_is_addi = (w_op == OP_ADDI);
    assign w_is_lw   = (w_op == OP_LW);
    assign w_is_sw   = (w_op == OP_SW);
    assign w_is_beq  = (w_op == OP_BEQ);

`ifdef MC_JUMP_EN
    logic              w_is_j;
    logic [ADDR_W-1:0] w_jtarget;
    assign w_is_j  = (w_op == OP_J);
    assign w_legal = (w_is_r & w_r_ok) | w_is_addi | w_is_lw | w_is_sw | w_is_beq | w_is_j;
    // Upper PC bits survive only when the address space is wider than the 28-bit jump field.
    if (ADDR_W > 28) begin : g_jhi
        assign w_jtarget = {r_pc[ADDR_W-1:28], r_ir[25:0], 2'b00};
    end else begin : g_jlo
        assign w_jtarget = ADDR_W'({r_ir[25:0], 2'b00});
    end
`else
    assign w_legal = (w_is_r & w_r_ok) | w_is_addi | w_is_lw | w_is_sw | w_is_beq;
`endif

    // Slots 0 and >=NREG are hard-wired zero, so their writes vanish and their reads return 0.
    for (genvar gi = 0; gi < 32; gi++) begin : g_rf
        if (gi > 0 && gi < NREG) begin : g_reg
            logic [XLEN-1:0] r_val;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    r_val <= '0;
                else if (w_rf_we && w_rf_waddr == 5'(gi))
                    r_val <= w_rf_wdata;
            end
            assign w_rf[gi] = r_val;
        end else begin : g_zero
            assign w_rf[gi] = '0;
        end
    end

    assign w_rf_we    = (r_state == S_WB);
    assign w_rf_waddr = w_is_r ? w_rd : w_rt;
    assign w_rf_wdata = w_is_lw ? r_mdr : r_alu;

    always_comb begin
        w_alu  = r_a + r_imm;
        w_r_ok = 1'b0;
        if (w_is_r) begin
            w_r_ok = 1'b1;
            case (w_funct)
                F_ADD:   w_alu = r_a + r_b;
                F_SUB:   w_alu = r_a - r_b;
                F_AND:   w_alu = r_a & r_b;
                F_OR:    w_alu = r_a | r_b;
                F_SLT:   w_alu = XLEN'($signed(r_a) < $signed(r_b));
                default: w_r_ok = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_FETCH;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH:  if (imem_ack) w_state_next = S_DECODE;
            S_DECODE: w_state_next = S_EXEC;
            S_EXEC: begin
                if (!w_legal || w_is_beq)
                    w_state_next = S_FETCH;
                else if (w_is_lw || w_is_sw)
                    w_state_next = S_MEM;
                else if (w_is_r || w_is_addi)
                    w_state_next = S_WB;
                else
                    w_state_next = S_FETCH;
            end
            S_MEM:    if (dmem_ack) w_state_next = w_is_sw ? S_FETCH : S_WB;
            S_WB:     w_state_next = S_FETCH;
            default:  w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_alu     <= '0;
            r_mdr     <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir <= imem_rdata;
                        r_pc <= r_pc + ADDR_W'(4);
                    end
                end
                S_DECODE: begin
                    r_a   <= w_rf[w_rs];
                    r_b   <= w_rf[w_rt];
                    r_imm <= XLEN'($signed(r_ir[15:0]));
                end
                S_EXEC: begin
                    r_alu <= w_alu;
                    if (!w_legal)
                        r_illegal <= 1'b1;
                    else if (w_is_beq && r_a == r_b)
                        r_pc <= r_pc + ADDR_W'(r_imm << 2);
`ifdef MC_JUMP_EN
                    else if (w_is_j)
                        r_pc <= w_jtarget;
`endif
                end
                S_MEM: begin
                    if (dmem_ack && !w_is_sw)
                        r_mdr <= dmem_rdata;
                end
                default: ;
            endcase
        end
    end

    // Requests are gated by reset so they fall in the very cycle reset asserts.
    assign imem_req   = (r_state == S_FETCH) && !reset;
    assign imem_addr  = r_pc;
    assign dmem_req   = (r_state == S_MEM) && !reset;
    assign dmem_we    = dmem_req && w_is_sw;
    assign dmem_addr  = ADDR_W'(r_alu);
    assign dmem_wdata = r_b;
    assign pc_o       = r_pc;
    assign state_o    = r_state;
    assign illegal_o  = r_illegal;
endmodule

// File: tb/tb_procesador_multiciclo.sv
// Directed bench for procesador_multiciclo (NREG=8) with behavioural wait-state instruction/data memories.
module tb_procesador_multiciclo;
    localparam int XLEN = 32;
    localparam int AW   = 10;
    localparam logic [5:0] ADDI = 6'h08, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, J = 6'h02;
    localparam logic [5:0] FADD = 6'h20, FSUB = 6'h22, FAND = 6'h24, FOR = 6'h25, FSLT = 6'h2A;

    logic            clk = 1'b0;
    logic            reset;
    logic            imem_req, imem_ack;
    logic [AW-1:0]   imem_addr;
    logic [31:0]     imem_rdata;
    logic            dmem_req, dmem_we, dmem_ack;
    logic [AW-1:0]   dmem_addr;
    logic [XLEN-1:0] dmem_wdata, dmem_rdata;
    logic [AW-1:0]   pc_o;
    logic [2:0]      state_o;
    logic            illegal_o;

    logic [31:0] imem [256];
    logic [31:0] dmem [16];
    int i_wait = 0, d_wait = 0, i_cnt = 0, d_cnt = 0;
    int checks = 0, errors = 0;

    procesador_multiciclo #(.XLEN(XLEN), .NREG(8), .ADDR_W(AW), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc_o(pc_o), .state_o(state_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    // Memories answer on the falling edge after i_wait/d_wait extra request cycles.
    always @(negedge clk) begin
        if (imem_req) begin
            imem_rdata = imem[imem_addr[9:2]];
            if (i_cnt == i_wait) begin
                imem_ack = 1'b1;
                i_cnt    = 0;
            end else begin
                imem_ack = 1'b0;
                i_cnt    = i_cnt + 1;
            end
        end else begin
            imem_ack = 1'b0;
            i_cnt    = 0;
        end
        if (dmem_req) begin
            if (d_cnt == d_wait) begin
                dmem_ack = 1'b1;
                d_cnt    = 0;
                if (dmem_we) dmem[dmem_addr[5:2]] = dmem_wdata;
                else         dmem_rdata = dmem[dmem_addr[5:2]];
            end else begin
                dmem_ack = 1'b0;
                d_cnt    = d_cnt + 1;
            end
        end else begin
            dmem_ack = 1'b0;
            d_cnt    = 0;
        end
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        for (int k = 0; k < 256; k++) imem[k] = '0;
        for (int k = 0; k < 16; k++) dmem[k] = '0;
        dmem[2] = 32'h5555; dmem[6] = 32'hDEAD; dmem[7] = 32'hBEEF; dmem[12] = 32'h1234;
        imem[0]  = enc_i(ADDI, 0, 1, 16'd5);
        imem[1]  = enc_i(ADDI, 0, 2, 16'hFFFD);
        imem[2]  = enc_r(1, 2, 3, FADD);
        imem[3]  = enc_r(2, 1, 4, FSLT);
        imem[4]  = enc_i(BEQ, 1, 1, 16'hFFFF);
        imem[5]  = enc_i(SW, 0, 3, 16'd8);
        imem[6]  = enc_i(LW, 0, 5, 16'd8);
        imem[7]  = enc_i(SW, 0, 5, 16'd12);
        imem[8]  = {J, 26'h10};
        imem[9]  = enc_i(BEQ, 0, 0, 16'd6);
        imem[16] = enc_i(SW, 0, 4, 16'd16);
        imem[17] = enc_i(ADDI, 0, 0, 16'd7);
        imem[18] = enc_i(ADDI, 0, 6, 16'd9);
        imem[19] = enc_i(SW, 0, 6, 16'd20);
        imem[20] = enc_r(0, 0, 6, FADD);
        imem[21] = enc_i(SW, 0, 6, 16'd24);
        imem[22] = enc_i(ADDI, 0, 9, 16'd77);
        imem[23] = enc_i(SW, 0, 9, 16'd28);
        imem[24] = enc_i(SW, 0, 1, 16'd32);
        imem[25] = enc_r(1, 2, 7, FSUB);
        imem[26] = enc_i(SW, 0, 7, 16'd36);
        imem[27] = enc_r(1, 2, 6, FAND);
        imem[28] = enc_r(1, 2, 7, FOR);
        imem[29] = enc_i(SW, 0, 6, 16'd40);
        imem[30] = enc_i(SW, 0, 7, 16'd44);
        imem[31] = enc_r(1, 2, 6, FSLT);
        imem[32] = enc_i(SW, 0, 6, 16'd48);
        imem[33] = enc_i(BEQ, 0, 0, 16'hFFFF);

        reset = 1'b1;
        step(2);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_pc", 32'(pc_o), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_illegal", 32'(illegal_o), 32'd0);
        reset = 1'b0;
        step(4);
        chk("first_instr_pc", 32'(pc_o), 32'h4);
        i_wait = 1000;
        step(3);
        chk("stall_req", 32'(imem_req), 32'd1);
        chk("stall_addr", 32'(imem_addr), 32'h4);
        chk("stall_state", 32'(state_o), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("midfetch_req_drop", 32'(imem_req), 32'd0);
        chk("midfetch_pc", 32'(pc_o), 32'd0);
        chk("midfetch_state", 32'(state_o), 32'd0);
        chk("midfetch_illegal", 32'(illegal_o), 32'd0);
        i_wait = 0;
        step(1);
        reset = 1'b0;

        step(15);
        chk("prog_cycle15_wb", 32'(state_o), 32'd4);
        step(1);
        chk("prog_cycle16_state", 32'(state_o), 32'd0);
        chk("prog_cycle16_pc", 32'(pc_o), 32'h10);

        step(1);
        chk("beq_fetch_pc", 32'(pc_o), 32'h14);
        step(2);
        chk("beq_taken_pc1", 32'(pc_o), 32'h10);
        step(3);
        chk("beq_taken_pc2", 32'(pc_o), 32'h10);
        imem[4] = enc_i(BEQ, 1, 2, 16'd4);
        step(3);
        chk("beq_not_taken_pc", 32'(pc_o), 32'h14);
        chk("beq_state", 32'(state_o), 32'd0);

        d_wait = 3;
        step(3);
        for (int k = 0; k < 4; k++) begin
            chk("sw_wait_state", 32'(state_o), 32'd3);
            chk("sw_wait_req", 32'(dmem_req), 32'd1);
            chk("sw_wait_we", 32'(dmem_we), 32'd1);
            chk("sw_wait_addr", 32'(dmem_addr), 32'd8);
            chk("sw_wait_wdata", dmem_wdata, 32'd2);
            step(1);
        end
        chk("sw_done_state", 32'(state_o), 32'd0);
        chk("sw_done_pc", 32'(pc_o), 32'h18);
        chk("sw_mem_r3", dmem[2], 32'd2);

        step(3);
        chk("lw_mem_req", 32'(dmem_req), 32'd1);
        chk("lw_mem_we", 32'(dmem_we), 32'd0);
        chk("lw_mem_addr", 32'(dmem_addr), 32'd8);
        step(4);
        chk("lw_cycle7_wb", 32'(state_o), 32'd4);
        step(1);
        chk("lw_cycle8_state", 32'(state_o), 32'd0);
        chk("lw_cycle8_pc", 32'(pc_o), 32'h1C);

        d_wait = 0;
        step(4);
        chk("lw_r5_value", dmem[3], 32'd2);
        chk("pre_jump_pc", 32'(pc_o), 32'h20);
        chk("pre_jump_illegal", 32'(illegal_o), 32'd0);

        step(3);
        chk("jump_state", 32'(state_o), 32'd0);
`ifdef MC_JUMP_EN
        chk("jump_pc", 32'(pc_o), 32'h40);
        chk("jump_illegal", 32'(illegal_o), 32'd0);
`else
        chk("jump_nop_pc", 32'(pc_o), 32'h24);
        chk("jump_illegal_set", 32'(illegal_o), 32'd1);
        step(3);
        chk("skip_pc", 32'(pc_o), 32'h40);
        chk("illegal_sticky", 32'(illegal_o), 32'd1);
`endif

        for (int k = 0; k < 400; k++) begin
            if (pc_o == AW'(32'h84) && state_o == 3'd0) break;
            step(1);
        end
        chk("end_reached_pc", 32'(pc_o), 32'h84);
        chk("slt_r4", dmem[4], 32'd1);
        chk("r0_write_ignored", dmem[5], 32'd9);
        chk("add_r0_r0", dmem[6], 32'd0);
        chk("r9_read_zero", dmem[7], 32'd0);
        chk("r1_not_aliased", dmem[8], 32'd5);
        chk("sub_result", dmem[9], 32'd8);
        chk("and_result", dmem[10], 32'd5);
        chk("or_result", dmem[11], 32'hFFFFFFFD);
        chk("slt_false", dmem[12], 32'd0);
`ifdef MC_JUMP_EN
        chk("final_illegal", 32'(illegal_o), 32'd0);
`else
        chk("final_illegal", 32'(illegal_o), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/procesador_multiciclo.md
Name: procesador_multiciclo

Overview:
Parametrised multicycle successor of the single-cycle MIPS-subset processor. One FSM-sequenced datapath: register bank, ALU, sign extension, PC and instruction register. Instruction and data memories sit outside the block behind req/ack handshakes, so wait-state memories are supported. Widths, register count and reset vector are generics.

Parameters:
XLEN, 32, datapath/register width (16..64); immediates sign-extended to XLEN
NREG, 32, number of architectural registers (2..32); r0 reads 0
ADDR_W, 10, byte-address width of PC and data address (>=4)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_W  fetch byte address (=PC)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  instruction word
dmem_req  out  1  data access request
dmem_we  out  1  1=store, 0=load; valid with dmem_req
dmem_addr  out  ADDR_W  data byte address (ALU result, truncated)
dmem_wdata  out  XLEN  store data (rt value)
dmem_ack  in  1  access complete; dmem_rdata valid for loads
dmem_rdata  in  XLEN  load data
pc_o  out  ADDR_W  current PC
state_o  out  3  FSM state code
illegal_o  out  1  sticky illegal-opcode flag

Behaviour:
- Reset (async): PC=RESET_PC, state=FETCH, all registers 0, IR=0, illegal_o=0, imem_req/dmem_req/dmem_we=0. Requests drop in the cycle reset asserts, including mid-wait.
- States/codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- FETCH: imem_req=1, imem_addr=PC held stable until imem_ack. On ack: IR<=imem_rdata, PC<=PC+4 (mod 2^ADDR_W), go to DECODE. No ack: stay indefinitely.
- DECODE: A<=R[rs], B<=R[rt], imm<=sext(IR[15:0]); go to EXEC.
- EXEC by opcode:
  - R-type 000000, funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed). Result latched; go to WB. Unknown funct counts as illegal.
  - addi 001000: A+imm; go to WB.
  - lw 100011 / sw 101011: addr=A+imm; go to MEM.
  - beq 000100: if A==B then PC<=PC+(imm<<2), else PC unchanged; go to FETCH.
- MEM: dmem_req=1, dmem_we=(sw), address/wdata held until dmem_ack. On ack: sw goes to FETCH; lw latches rdata and goes to WB.
- WB: write rd (R-type) or rt (addi/lw). Writes to index 0 or index >=NREG are discarded. Go to FETCH.
- Latency with zero-wait memories (ack in the first request cycle): beq 3, sw 4, R/addi 4, lw 5 cycles.
- Arithmetic wraps modulo 2^XLEN; carry/overflow ignored. Reads of index >=NREG return 0.
- Illegal opcode/funct: illegal_o<=1 (sticky until reset), instruction is a NOP, EXEC goes to FETCH.
- Register-file write happens only in WB, so a DECODE read never sees a same-cycle write hazard.

Optional Feature:
MC_JUMP_EN: defined -> opcode 000010 (j) is legal. In EXEC, PC<=(PC[ADDR_W-1:28] if ADDR_W>28) concatenated with IR[25:0]<<2, truncated to ADDR_W; go to FETCH, 3 cycles. Undefined -> opcode 000010 is illegal: sets illegal_o, executes as NOP.

Test Plan:
- Reset mid-fetch with imem_req=1 and no ack -> imem_req=0 immediately, pc_o=RESET_PC, state_o=0, illegal_o=0.
- Zero-wait program: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1 -> r3=2, r4=1; done in 16 cycles after reset release.
- sw r3,8(r0) then lw r5,8(r0), dmem_ack delayed 3 cycles each -> dmem_addr=8 and dmem_wdata=2 held stable through the wait; r5=2; lw takes 8 cycles.
- beq r1,r1,-1 at PC=0x10 -> PC=0x10 again (taken loop); beq r1,r2,+4 -> PC=0x14 (not taken).
- addi r0,r0,7 then add r6,r0,r0 -> r6=0; NREG=8: write to r9 discarded, read of r9 returns 0.
- Opcode 000010 at PC=0x20, target field 0x10 -> MC_JUMP_EN: PC=0x40, illegal_o=0; without: PC=0x24, illegal_o=1 and stays 1.
